// File: rtl/accumulator_pkg.sv
// Shared types and constants for the 8-bit running-sum accumulator.
package accumulator_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_CLEAR = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/full_adder_8_bits_behavior.sv
// Combinational 8-cell ripple-carry adder with scalar sum outputs S1 (LSB) .. S8 (MSB).
module full_adder_8_bits_behavior (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       CIN,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic       S5,
  output logic       S6,
  output logic       S7,
  output logic       S8,
  output logic       COUT
);

  logic [7:0] w_sum;
  logic       w_carry;

  // Carry ripples LSB to MSB through one full-adder cell per bit.
  always_comb begin
    w_sum   = '0;
    w_carry = CIN;
    for (int i = 0; i < 8; i++) begin
      w_sum[i] = A[i] ^ B[i] ^ w_carry;
      w_carry  = (A[i] & B[i]) | (w_carry & (A[i] ^ B[i]));
    end
  end

  assign {S8, S7, S6, S5, S4, S3, S2, S1} = w_sum;
  assign COUT = w_carry;

endmodule

// File: rtl/accumulator_8_bits.sv
// Clocked running-sum stage around the ripple adder: valid/ready operand input,
// two-cycle IDLE/EXEC handshake, carry/overflow status and saturating ADD counter.
module accumulator_8_bits #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       IN_OP,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic [WIDTH-1:0] ACC,
  output logic             COUT,
  output logic             OVF,
  output logic [7:0]       COUNT,
  output logic             OUT_VALID
);

  import accumulator_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           r_state;
  op_e              r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_acc;
  logic             r_cout;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic             r_out_valid;

  logic [WIDTH-1:0] w_sum;
  logic             w_carry;

  full_adder_8_bits_behavior u_adder (
    .A    (r_acc),
    .B    (r_data),
    .CIN  (1'b0),
    .S1   (w_sum[0]),
    .S2   (w_sum[1]),
    .S3   (w_sum[2]),
    .S4   (w_sum[3]),
    .S5   (w_sum[4]),
    .S6   (w_sum[5]),
    .S7   (w_sum[6]),
    .S8   (w_sum[7]),
    .COUT (w_carry)
  );

  // IDLE latches the offered op; EXEC commits it and pulses OUT_VALID.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_op        <= OP_ADD;
      r_data      <= '0;
      r_acc       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (IN_VALID) begin
            r_op    <= op_e'(IN_OP);
            r_data  <= IN_DATA;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b1;
          case (r_op)
            OP_ADD: begin
              r_acc  <= w_sum;
              r_cout <= w_carry;
              r_ovf  <= r_ovf | w_carry;
              if (r_count != CNT_MAX) begin
                r_count <= r_count + CNT_W'(1);
              end
            end
            OP_LOAD: begin
              r_acc  <= r_data;
              r_cout <= 1'b0;
            end
            OP_CLEAR: begin
              r_acc   <= '0;
              r_cout  <= 1'b0;
              r_ovf   <= 1'b0;
              r_count <= '0;
            end
            OP_RSVD: begin
              r_acc <= r_acc;
            end
          endcase
        end
      endcase
    end
  end

  assign IN_READY  = (r_state == ST_IDLE);
  assign ACC       = r_acc;
  assign COUT      = r_cout;
  assign OVF       = r_ovf;
  assign COUNT     = r_count;
  assign OUT_VALID = r_out_valid;

endmodule

// File: tb/tb_accumulator_8_bits.sv
// Self-checking bench for accumulator_8_bits against an arithmetic reference model.
module tb_accumulator_8_bits;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [1:0] IN_OP = 2'b00;
  logic [7:0] IN_DATA = 8'h00;
  logic [7:0] ACC;
  logic       COUT;
  logic       OVF;
  logic [7:0] COUNT;
  logic       OUT_VALID;

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_acc   = 0;
  int m_cout  = 0;
  int m_ovf   = 0;
  int m_count = 0;

  int pulses   = 0;
  bit prev_ov  = 1'b0;
  bit ov_twice = 1'b0;

  accumulator_8_bits #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_OP     (IN_OP),
    .IN_DATA   (IN_DATA),
    .ACC       (ACC),
    .COUT      (COUT),
    .OVF       (OVF),
    .COUNT     (COUNT),
    .OUT_VALID (OUT_VALID)
  );

  always #5 CLK = ~CLK;

  // OUT_VALID pulse counter, sampled mid-cycle
  always @(negedge CLK) begin
    if (OUT_VALID === 1'b1) pulses++;
    if (OUT_VALID === 1'b1 && prev_ov) ov_twice = 1'b1;
    prev_ov = (OUT_VALID === 1'b1);
  end

  task automatic model_reset();
    m_acc = 0; m_cout = 0; m_ovf = 0; m_count = 0;
  endtask

  task automatic model_apply(input int op, input int data);
    int sum;
    case (op)
      0: begin
        sum     = m_acc + data;
        m_cout  = (sum > 255) ? 1 : 0;
        m_ovf   = (m_ovf != 0 || m_cout != 0) ? 1 : 0;
        m_acc   = sum % 256;
        m_count = (m_count + 1 > 255) ? 255 : m_count + 1;
      end
      1: begin m_acc = data; m_cout = 0; end
      2: begin m_acc = 0; m_cout = 0; m_ovf = 0; m_count = 0; end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    RST = 1'b1; IN_VALID = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
  endtask

  // one handshake: wait for ready, transfer, let EXEC commit; returns #1 after commit edge
  task automatic do_op(input logic [1:0] op, input logic [7:0] data);
    int n = 0;
    while (IN_READY !== 1'b1 && n < 10) begin @(posedge CLK); #1; n++; end
    checks++;
    if (IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: IN_READY=%b required 1", IN_READY);
    end
    IN_VALID = 1'b1; IN_OP = op; IN_DATA = data;
    @(posedge CLK); #1;
    IN_VALID = 1'b0; IN_OP = 2'($urandom); IN_DATA = 8'($urandom);
    @(posedge CLK); #1;
    model_apply(int'(op), int'(data));
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(posedge CLK); @(posedge CLK); #1;
    checks++;
    if ({ACC, COUT, OVF, COUNT, OUT_VALID, IN_READY} !== {8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: ACC=%h COUT=%b OVF=%b COUNT=%0d OV=%b RDY=%b required 00/0/0/0/0/1",
               ACC, COUT, OVF, COUNT, OUT_VALID, IN_READY);
    end
    RST = 1'b0;
    model_reset();
  endtask

  task automatic test_load_add();
    int p0 = pulses;
    do_reset();
    do_op(2'b01, 8'h88);
    checks++;
    if (ACC !== 8'h88 || OUT_VALID !== 1'b1) begin
      errors++;
      $display("FAIL load: ACC=%h OV=%b required 88/1", ACC, OUT_VALID);
    end
    do_op(2'b00, 8'h26);
    checks++;
    if ({ACC, COUT, OVF, COUNT, OUT_VALID} !== {8'hAE, 1'b0, 1'b0, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL add: ACC=%h COUT=%b OVF=%b COUNT=%0d OV=%b required AE/0/0/1/1",
               ACC, COUT, OVF, COUNT, OUT_VALID);
    end
    @(posedge CLK); #1;
    checks++;
    if (pulses - p0 !== 2) begin
      errors++;
      $display("FAIL load_add_pulses: got %0d required 2", pulses - p0);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    do_op(2'b01, 8'hC3);
    do_op(2'b00, 8'h3C);
    checks++;
    if (ACC !== 8'hFF) begin
      errors++;
      $display("FAIL ovf_ff: ACC=%h required FF", ACC);
    end
    do_op(2'b00, 8'h01);
    checks++;
    if ({ACC, COUT, OVF} !== {8'h00, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_wrap: ACC=%h COUT=%b OVF=%b required 00/1/1", ACC, COUT, OVF);
    end
    do_op(2'b00, 8'h05);
    checks++;
    if ({ACC, COUT, OVF, COUNT} !== {8'h05, 1'b0, 1'b1, 8'd3}) begin
      errors++;
      $display("FAIL ovf_sticky: ACC=%h COUT=%b OVF=%b COUNT=%0d required 05/0/1/3",
               ACC, COUT, OVF, COUNT);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    do_reset();
    p0 = pulses;
    ov_twice = 1'b0;
    IN_VALID = 1'b1; IN_OP = 2'b00; IN_DATA = 8'h01;
    for (int j = 1; j <= 8; j++) begin
      @(posedge CLK); #1;
      if (j == 8) IN_VALID = 1'b0;
      if (j % 2 == 0) model_apply(0, 1);
      checks++;
      if (IN_READY !== 1'(j % 2 == 0) || OUT_VALID !== 1'(j % 2 == 0)) begin
        errors++;
        $display("FAIL b2b_edge%0d: RDY=%b OV=%b required %0d", j, IN_READY, OUT_VALID, (j % 2 == 0));
      end
    end
    @(posedge CLK); #1;
    checks++;
    if (ACC !== 8'h04 || pulses - p0 !== 4 || ov_twice) begin
      errors++;
      $display("FAIL b2b_final: ACC=%h pulses=%0d double=%b required 04/4/0", ACC, pulses - p0, ov_twice);
    end
  endtask

  task automatic test_reset_in_exec();
    int p0;
    do_reset();
    do_op(2'b00, 8'h20);
    @(posedge CLK); #1;
    p0 = pulses;
    IN_VALID = 1'b1; IN_OP = 2'b00; IN_DATA = 8'h10;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    checks++;
    if ({ACC, COUNT, OUT_VALID, IN_READY} !== {8'h00, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL rst_exec: ACC=%h COUNT=%0d OV=%b RDY=%b required 00/0/0/1", ACC, COUNT, OUT_VALID, IN_READY);
    end
    @(posedge CLK); #1;
    checks++;
    if (pulses - p0 !== 0 || ACC !== 8'h00) begin
      errors++;
      $display("FAIL rst_exec_drop: pulses=%0d ACC=%h required 0/00", pulses - p0, ACC);
    end
  endtask

  task automatic test_reserved_clear();
    do_reset();
    do_op(2'b01, 8'hFF);
    do_op(2'b00, 8'h01);
    do_op(2'b11, 8'h55);
    checks++;
    if ({ACC, COUT, OVF, COUNT, OUT_VALID} !== {8'h00, 1'b1, 1'b1, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL reserved: ACC=%h COUT=%b OVF=%b COUNT=%0d OV=%b required 00/1/1/1/1",
               ACC, COUT, OVF, COUNT, OUT_VALID);
    end
    do_op(2'b10, 8'hA5);
    checks++;
    if ({ACC, COUT, OVF, COUNT} !== {8'h00, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL clear: ACC=%h COUT=%b OVF=%b COUNT=%0d required 00/0/0/0", ACC, COUT, OVF, COUNT);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 260; i++) begin
      do_op(2'b00, 8'($urandom));
      if (i >= 252) begin
        checks++;
        if ({ACC, COUT, OVF, COUNT} !== {8'(m_acc), 1'(m_cout), 1'(m_ovf), 8'(m_count)}) begin
          errors++;
          $display("FAIL sat_%0d: ACC=%h COUT=%b OVF=%b COUNT=%0d required %h/%0d/%0d/%0d",
                   i, ACC, COUT, OVF, COUNT, m_acc, m_cout, m_ovf, m_count);
        end
      end
    end
    checks++;
    if (COUNT !== 8'd255) begin
      errors++;
      $display("FAIL sat_final: COUNT=%0d required 255", COUNT);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        IN_OP = 2'($urandom); IN_DATA = 8'($urandom);
        @(posedge CLK); #1;
      end
      do_op(op, 8'($urandom));
      checks++;
      if ({ACC, COUT, OVF, COUNT, OUT_VALID} !== {8'(m_acc), 1'(m_cout), 1'(m_ovf), 8'(m_count), 1'b1}) begin
        errors++;
        $display("FAIL rand_%0d op=%0d: ACC=%h COUT=%b OVF=%b COUNT=%0d OV=%b required %h/%0d/%0d/%0d/1",
                 i, op, ACC, COUT, OVF, COUNT, OUT_VALID, m_acc, m_cout, m_ovf, m_count);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_add();
    test_overflow();
    test_back_to_back();
    test_reset_in_exec();
    test_reserved_clear();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/accumulator_8_bits.md
# accumulator_8_bits

Registered 8-bit accumulator that sits directly downstream of `full_adder_8_bits_behavior`. It consumes the adder's S1..S8/COUT outputs and feeds ACC back as the A operand. The block turns the combinational ripple adder into a clocked running-sum stage with a valid/ready operand interface, a carry/overflow status and an operation counter.

## Interface
Parameters:
- WIDTH, 8, datapath width. Fixed at 8 because the adder sub-module has scalar 8-bit ports; any other value is illegal.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- IN_VALID  input  1  operand/op offered this cycle.
- IN_READY  output  1  block can accept; a transfer occurs when IN_VALID && IN_READY at a rising edge.
- IN_OP  input  2  00 ADD, 01 LOAD, 10 CLEAR, 11 reserved.
- IN_DATA  input  8  operand, bit 0 = LSB.
- ACC  output  8  accumulator value.
- COUT  output  1  carry-out of the most recent ADD.
- OVF  output  1  sticky unsigned overflow; set by any ADD with carry-out.
- COUNT  output  8  number of completed ADDs, saturating at 255.
- OUT_VALID  output  1  one-cycle pulse: result of the last accepted op is on ACC/COUT/OVF/COUNT.

## Operation
- The FSM has two states, IDLE and EXEC. IDLE: IN_READY=1. On transfer, latch IN_OP/IN_DATA and go to EXEC. EXEC: IN_READY=0. Apply the op at the edge ending EXEC and return to IDLE.
- ADD: ACC←(ACC+DATA) mod 256 via the adder sub-module with CIN tied to 0. COUT←adder carry. OVF←OVF|carry. COUNT←min(COUNT+1,255).
- LOAD: ACC←DATA, COUT←0. OVF and COUNT are unchanged.
- CLEAR: ACC, COUT, OVF and COUNT all ←0.
- Reserved (11): the op is accepted and OUT_VALID pulses. No other state changes.
- Reset values: ACC=0, COUT=0, OVF=0, COUNT=0, OUT_VALID=0, state=IDLE, so IN_READY=1 in the first cycle after reset.
- RST has priority over everything. If RST is asserted in EXEC, the op is dropped, no OUT_VALID is produced and all registers return to their reset values.
- When COUNT is at 255, an ADD leaves it at 255; ACC and flags still update.
- IN_DATA and IN_OP are ignored when no transfer occurs. Changes to them after acceptance have no effect.

## Timing
- Transfer at edge k puts the block in EXEC. State is updated at edge k+1. OUT_VALID=1 for the cycle between edges k+1 and k+2.
- Peak throughput is one op per 2 cycles. A new transfer may occur at edge k+2, during the OUT_VALID cycle.
- OUT_VALID is registered and never high for two consecutive cycles.
- IN_READY is a function of state only, with no combinational path from IN_VALID.
- The adder path (ACC, latched operand → next ACC) is a single combinational ripple of 8 cells within one cycle.

## Structure
- Package `accumulator_pkg` holds the op enum (OP_ADD, OP_LOAD, OP_CLEAR, OP_RSVD), the WIDTH constant and the state enum (ST_IDLE, ST_EXEC).
- One sub-module: `full_adder_8_bits_behavior`. A = ACC bits, B = latched operand bits, CIN = 0. S1..S8 and COUT are the next-sum inputs.
- Everything else lives in a single clocked process plus output assigns.

## Test plan
- Reset: hold RST 2 cycles → ACC=0x00, COUT=0, OVF=0, COUNT=0, OUT_VALID=0, IN_READY=1.
- LOAD 0x88, then ADD 0x26 → ACC=0xAE, COUT=0, OVF=0, COUNT=1, with one OUT_VALID pulse per op.
- LOAD 0xC3, ADD 0x3C → ACC=0xFF. Then ADD 0x01 → ACC=0x00, COUT=1, OVF=1. Then ADD 0x05 → ACC=0x05, COUT=0, OVF still 1, COUNT=3.
- IN_VALID held high with 4 ADD 0x01 from ACC=0 → IN_READY alternates 1/0, transfers every 2 cycles, 4 OUT_VALID pulses, ACC=0x04 after the 8th edge.
- ACC=0x20, accept ADD 0x10, assert RST during EXEC → next cycle ACC=0x00, COUNT=0, no OUT_VALID, IN_READY=1.
- After overflow, op 11 with DATA 0x55 → OUT_VALID pulses, nothing else changes. Then CLEAR → ACC=0, COUT=0, OVF=0, COUNT=0.
